// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store control unit: size codes, FSM states
// and lane helpers used by the store path and the load extraction path.
package lsu_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Size code 3 falls through to word everywhere below.
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_extract.sv
// Combinational lane select and sign/zero extension of a 32-bit read word.
module lsu_load_extract
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    data = {{24{sext & b[7]}}, b};
            SZ_H:    data = {{16{sext & h[15]}}, h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control between the MEM stage and the memory data port.
// Memory-side outputs and rdata/done/err are registered; stall is combinational.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned MIN_WAIT = 2,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W+1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              stall,
    output logic              err,
    output logic              mem_re,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    input  logic              mem_busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [1:0]        alo_q;
    logic [31:0]       ext_data;

    logic              done_nxt, err_nxt, re_nxt;
    logic [3:0]        we_nxt;
    logic [31:0]       rdata_nxt, din_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              rd_ok, rd_timeout;

    lsu_load_extract u_extract (
        .word    (mem_dout),
        .addr_lo (alo_q),
        .size    (size_q),
        .sext    (sext_q),
        .data    (ext_data)
    );

    assign stall      = (state == ST_IDLE && req) || state == ST_RD || state == ST_WR;
    assign rd_ok      = cnt >= CNT_W'(MIN_WAIT - 1) && !mem_busy;
    assign rd_timeout = cnt == CNT_W'(TIMEOUT - 1);

    // Next values for the registered outputs are decided here alongside the state.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        re_nxt    = 1'b0;
        we_nxt    = '0;
        rdata_nxt = rdata;
        din_nxt   = mem_din;
        addr_nxt  = mem_addr;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (misaligned(size, addr[1:0])) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                        rdata_nxt = '0;
                    end else if (we) begin
                        state_nxt = ST_WR;
                        we_nxt    = lane_mask(size, addr[1:0]);
                        din_nxt   = lane_data(size, wdata);
                        addr_nxt  = addr[ADDR_W+1:2];
                    end else begin
                        state_nxt = ST_RD;
                        re_nxt    = 1'b1;
                        addr_nxt  = addr[ADDR_W+1:2];
                    end
                end
            end
            ST_RD: begin
                if (rd_ok) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    rdata_nxt = ext_data;
                end else if (rd_timeout) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                end else begin
                    re_nxt = 1'b1;
                end
            end
            ST_WR: begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
                rdata_nxt = '0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            size_q   <= '0;
            sext_q   <= 1'b0;
            alo_q    <= '0;
            rdata    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_re   <= 1'b0;
            mem_we   <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ST_RD) ? cnt + CNT_W'(1) : '0;
            if (state == ST_IDLE && req) begin
                size_q <= size;
                sext_q <= sext;
                alo_q  <= addr[1:0];
            end
            rdata    <= rdata_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            mem_re   <= re_nxt;
            mem_we   <= we_nxt;
            mem_addr <= addr_nxt;
            mem_din  <= din_nxt;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Table-driven bench for lsu_ctrl with a scoreboard queue of expected completions.
module tb_lsu_ctrl;

    localparam int unsigned ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              req, we, sext;
    logic [1:0]        size;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata, rdata, mem_din, mem_dout;
    logic              done, stall, err, mem_re, mem_busy;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;

    lsu_ctrl #(.ADDR_W(ADDR_W), .MIN_WAIT(2), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall),
        .err(err), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        int          busy_lo;   // first cycle in which mem_busy is low
        logic        exp_re1;
        logic [3:0]  exp_we1;
        logic [31:0] exp_din;
        logic [6:0]  exp_addr;
        int          done_cyc;
        logic        exp_err;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sx,
                                input logic [8:0] a, input logic [31:0] wd, input logic [31:0] dt,
                                input int blo, input logic re1, input logic [3:0] we1,
                                input logic [31:0] din, input logic [6:0] ma, input int dc,
                                input logic e, input logic cr, input logic [31:0] rd);
        vec_t v;
        v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.wdata = wd; v.dout = dt;
        v.busy_lo = blo; v.exp_re1 = re1; v.exp_we1 = we1; v.exp_din = din;
        v.exp_addr = ma; v.done_cyc = dc; v.exp_err = e; v.chk_rdata = cr; v.exp_rdata = rd;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v, input bit drop_req);
        int   cyc;
        bit   got;
        int   stall_bad;
        vec_t e;
        @(posedge clk); #1;
        req = 1'b1; we = v.we; size = v.size; sext = v.sext; addr = v.addr;
        wdata = v.wdata; mem_dout = v.dout; mem_busy = (0 < v.busy_lo);
        sb.push_back(v);
        cyc = 0; got = 1'b0; stall_bad = 0;
        while (!got && cyc <= 40) begin
            @(negedge clk);
            if (cyc == 0) chk($sformatf("v%0d stall_req", idx), 32'(stall), 32'd1);
            if (cyc == 1) begin
                chk($sformatf("v%0d mem_re_c1", idx), 32'(mem_re), 32'(v.exp_re1));
                chk($sformatf("v%0d mem_we_c1", idx), 32'(mem_we), 32'(v.exp_we1));
                if (v.exp_we1 != 4'b0000)
                    chk($sformatf("v%0d mem_din_c1", idx), mem_din, v.exp_din);
                if (v.exp_re1 || v.exp_we1 != 4'b0000)
                    chk($sformatf("v%0d mem_addr_c1", idx), 32'(mem_addr), 32'(v.exp_addr));
                if (drop_req) req = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                e = sb.pop_front();
                chk($sformatf("v%0d done_cycle", idx), 32'(cyc), 32'(e.done_cyc));
                chk($sformatf("v%0d err", idx), 32'(err), 32'(e.exp_err));
                if (e.chk_rdata) chk($sformatf("v%0d rdata", idx), rdata, e.exp_rdata);
                chk($sformatf("v%0d stall_done", idx), 32'(stall), 32'd0);
                chk($sformatf("v%0d port_idle_done", idx), {27'd0, mem_re, mem_we}, 32'd0);
                req = 1'b0;
            end else if (!stall) begin
                stall_bad++;
            end
            @(posedge clk); #1;
            cyc++;
            mem_busy = (cyc < v.busy_lo);
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL v%0d done_wait: got no done within 40 cycles, expected cycle %0d", idx, v.done_cyc);
            void'(sb.pop_front());
            req = 1'b0;
        end
        chk($sformatf("v%0d stall_held", idx), 32'(stall_bad), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d done_pulse", idx), 32'(done), 32'd0);
    endtask

    initial begin
        //          we   sz     sx   addr    wdata         dout          blo re  we1      din           ma   dc e  cr rdata
        vecs[0]  = mk(1, 2'd2, 0, 9'h00C, 32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 32'hDEADBEEF, 7'd3,  2, 0, 0, 32'h0);
        vecs[1]  = mk(1, 2'd0, 0, 9'h006, 32'h000000A5, 32'h0,        0, 0, 4'b0100, 32'hA5A5A5A5, 7'd1,  2, 0, 0, 32'h0);
        vecs[2]  = mk(1, 2'd1, 0, 9'h00A, 32'h1234BEEF, 32'h0,        0, 0, 4'b1100, 32'hBEEFBEEF, 7'd2,  2, 0, 0, 32'h0);
        vecs[3]  = mk(0, 2'd0, 1, 9'h003, 32'h0,        32'h80112233, 2, 1, 4'b0000, 32'h0,        7'd0,  3, 0, 1, 32'hFFFFFF80);
        vecs[4]  = mk(0, 2'd0, 0, 9'h003, 32'h0,        32'h80112233, 2, 1, 4'b0000, 32'h0,        7'd0,  3, 0, 1, 32'h00000080);
        vecs[5]  = mk(0, 2'd1, 1, 9'h002, 32'h0,        32'h9ABC1234, 6, 1, 4'b0000, 32'h0,        7'd0,  7, 0, 1, 32'hFFFF9ABC);
        vecs[6]  = mk(0, 2'd1, 1, 9'h000, 32'h0,        32'h9ABC1234, 0, 1, 4'b0000, 32'h0,        7'd0,  3, 0, 1, 32'h00001234);
        vecs[7]  = mk(0, 2'd2, 1, 9'h010, 32'h0,        32'h80000001, 0, 1, 4'b0000, 32'h0,        7'd4,  3, 0, 1, 32'h80000001);
        vecs[8]  = mk(0, 2'd0, 1, 9'h001, 32'h0,        32'h00007F00, 0, 1, 4'b0000, 32'h0,        7'd0,  3, 0, 1, 32'h0000007F);
        vecs[9]  = mk(0, 2'd2, 0, 9'h005, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        7'd0,  1, 1, 0, 32'h0);
        vecs[10] = mk(1, 2'd1, 0, 9'h003, 32'h11112222, 32'h0,        0, 0, 4'b0000, 32'h0,        7'd0,  1, 1, 0, 32'h0);
        vecs[11] = mk(0, 2'd2, 0, 9'h008, 32'h0,        32'h55555555, 99, 1, 4'b0000, 32'h0,       7'd2, 16, 1, 1, 32'h0);
        vecs[12] = mk(0, 2'd2, 0, 9'h1FC, 32'h0,        32'h12345678, 15, 1, 4'b0000, 32'h0,       7'd127, 16, 0, 1, 32'h12345678);
        vecs[13] = mk(1, 2'd3, 0, 9'h004, 32'hCAFEF00D, 32'h0,        0, 0, 4'b1111, 32'hCAFEF00D, 7'd1,  2, 0, 0, 32'h0);
        vecs[14] = mk(0, 2'd0, 1, 9'h002, 32'h0,        32'h00FF0000, 0, 1, 4'b0000, 32'h0,        7'd0,  3, 0, 1, 32'hFFFFFFFF);

        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0; addr = '0;
        wdata = '0; mem_dout = '0; mem_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {rdata[31:4] | mem_din[31:4] | {21'd0, mem_addr},
                              done, stall, err, mem_re} | {28'd0, mem_we}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i], 1'b0);

        // req dropped after acceptance must not abort the load
        run_vec(100, vecs[5], 1'b1);

        // asynchronous reset in the middle of a read
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 9'h020; mem_busy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rd_re_before", 32'(mem_re), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_rd_re_after", 32'(mem_re), 32'd0);
        chk("rst_rd_done_after", 32'(done), 32'd0);
        chk("rst_rd_we_after", 32'(mem_we), 32'd0);
        req = 1'b0;
        @(posedge clk); #1; rst = 1'b0; mem_busy = 1'b0;
        run_vec(200, vecs[3], 1'b0);
        run_vec(201, vecs[0], 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
